// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single-port unified MEM array between data (D), fetch (I) and loader (L) ports.
// Optional L aging is enabled by defining MIPS_ARB_AGING_EN.
module mips_mem_arbiter #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
`ifdef MIPS_ARB_AGING_EN
    ,
    parameter int unsigned AGE_MAX = 4
`endif
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] rdata,
    output logic          locked,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;
    logic   boost;

`ifdef MIPS_ARB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] age;

    assign boost = (state == IDLE) && l_req && (age == AGE_W'(AGE_MAX));

    // Counts consecutive IDLE cycles in which L asked but lost arbitration
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (l_gnt || !l_req) begin
            age <= '0;
        end else if ((state == IDLE) && (age != AGE_W'(AGE_MAX))) begin
            age <= age + AGE_W'(1);
        end
    end
`else
    assign boost = 1'b0;
`endif

    // One-hot grant; held low while reset is asserted
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_n) begin
            if (state == LOCKED) begin
                l_gnt = l_req;
            end else if (boost) begin
                l_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end else if (l_gnt) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    assign mem_en = d_gnt | i_gnt | l_gnt;
    assign rdata  = mem_rdata;

    // Lock state plus the one-cycle-delayed read-valid steering
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            locked   <= 1'b0;
            d_rvalid <= 1'b0;
            i_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
        end else begin
            d_rvalid <= d_gnt & ~d_we;
            i_rvalid <= i_gnt;
            l_rvalid <= l_gnt & ~l_we;
            case (state)
                IDLE: begin
                    if (l_gnt && l_lock) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!l_lock) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level arbitration model and a shadow memory.
module tb_mips_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int AGE_MAX = 4;
`ifdef MIPS_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          d_req, d_we, i_req, l_req, l_we, l_lock;
    logic [AW-1:0] d_addr, i_addr, l_addr;
    logic [DW-1:0] d_wdata, l_wdata;
    logic          d_gnt, d_rvalid, i_gnt, i_rvalid, l_gnt, l_rvalid;
    logic [DW-1:0] rdata;
    logic          locked, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    mips_mem_arbiter dut (
        .clk1(clk1), .rst_n(rst_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .rdata(rdata), .locked(locked),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory the arbiter drives
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata = mem[mem_addr];
        end
    end

    task automatic idle_inputs();
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;
    endtask

    task automatic preload();
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]     = $urandom;
            ref_mem[a] = mem[a];
        end
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        idle_inputs();
        d_req = 1'b1; i_req = 1'b1; l_req = 1'b1;
        @(negedge clk1); #1;
        got = {d_gnt, i_gnt, l_gnt, mem_en};
        checks++;
        if (got !== 4'b0) begin errors++; $display("FAIL reset_gnts got %b expected 0000", got); end
        got = {d_rvalid, i_rvalid, l_rvalid, locked};
        checks++;
        if (got !== 4'b0) begin errors++; $display("FAIL reset_regs got %b expected 0000", got); end
        @(negedge clk1);
        rst_n = 1'b1;
        idle_inputs();
        l_req = 1'b1; l_lock = 1'b1; l_addr = AW'(2);
        #1;
        checks++;
        if (l_gnt !== 1'b1) begin errors++; $display("FAIL reset_lgnt got %b expected 1", l_gnt); end
        @(posedge clk1); #1;
        d_req = 1'b1;
        checks++;
        if ({locked, l_rvalid} !== 2'b11) begin
            errors++; $display("FAIL reset_prelock got %b expected 11", {locked, l_rvalid});
        end
        #1 rst_n = 1'b0;
        #1;
        got = {d_gnt, i_gnt, l_gnt, mem_en};
        checks++;
        if (got !== 4'b0) begin errors++; $display("FAIL reset_mid_gnts got %b expected 0000", got); end
        got = {d_rvalid, i_rvalid, l_rvalid, locked};
        checks++;
        if (got !== 4'b0) begin errors++; $display("FAIL reset_mid_regs got %b expected 0000", got); end
        @(negedge clk1);
        rst_n = 1'b1;
        idle_inputs();
        d_req = 1'b1; d_addr = AW'(6);
        #1;
        checks++;
        if ({d_gnt, locked} !== 2'b10) begin
            errors++; $display("FAIL reset_idle got %b expected 10", {d_gnt, locked});
        end
        @(negedge clk1);
        idle_inputs();
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || rdata !== ref_mem[6]) begin
            errors++; $display("FAIL reset_read got %b/%h expected 1/%h", d_rvalid, rdata, ref_mem[6]);
        end
    endtask

    task automatic test_priority();
        @(negedge clk1);
        idle_inputs();
        d_req = 1'b1; d_addr = AW'(5);
        i_req = 1'b1; i_addr = AW'(0);
        l_req = 1'b1; l_addr = AW'(9);
        #1;
        checks++;
        if ({d_gnt, i_gnt, l_gnt} !== 3'b100 || mem_addr !== AW'(5)) begin
            errors++; $display("FAIL prio_gnt got %b addr %0d expected 100 addr 5", {d_gnt, i_gnt, l_gnt}, mem_addr);
        end
        @(negedge clk1);
        idle_inputs();
        #1;
        checks++;
        if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b100 || rdata !== ref_mem[5]) begin
            errors++; $display("FAIL prio_read got %b/%h expected 100/%h", {d_rvalid, i_rvalid, l_rvalid}, rdata, ref_mem[5]);
        end
    endtask

    task automatic test_fetch_stream();
        logic [DW-1:0] fv [4];
        fv[0] = 32'h2801000a; fv[1] = 32'h28020014; fv[2] = 32'h28030019; fv[3] = 32'h0ce77800;
        for (int k = 0; k < 4; k++) begin
            mem[k] = fv[k]; ref_mem[k] = fv[k];
        end
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk1);
            idle_inputs();
            if (k < 4) begin i_req = 1'b1; i_addr = AW'(k); end
            #1;
            checks++;
            if (i_gnt !== (k < 4)) begin errors++; $display("FAIL fetch_gnt%0d got %b", k, i_gnt); end
            if (k > 0) begin
                checks++;
                if (i_rvalid !== 1'b1 || rdata !== fv[k-1]) begin
                    errors++; $display("FAIL fetch_data%0d got %b/%h expected 1/%h", k, i_rvalid, rdata, fv[k-1]);
                end
            end
        end
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_en got %b expected 0", mem_en); end
        @(negedge clk1); #1;
        checks++;
        if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b000) begin
            errors++; $display("FAIL idle_rvalid got %b expected 000", {d_rvalid, i_rvalid, l_rvalid});
        end
    endtask

    task automatic test_write();
        @(negedge clk1);
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = AW'(3); d_wdata = 32'd7;
        #1;
        checks++;
        if ({d_gnt, mem_we} !== 2'b11 || mem_addr !== AW'(3) || mem_wdata !== 32'd7) begin
            errors++; $display("FAIL write_strobe got %b addr %0d data %h expected 11 3 7", {d_gnt, mem_we}, mem_addr, mem_wdata);
        end
        ref_mem[3] = 32'd7;
        @(negedge clk1);
        idle_inputs();
        #1;
        checks++;
        if (d_rvalid !== 1'b0) begin errors++; $display("FAIL write_rvalid got %b expected 0", d_rvalid); end
    endtask

    task automatic test_lock();
        @(negedge clk1);
        idle_inputs();
        l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = AW'(8); l_wdata = 32'hfc000000;
        #1;
        checks++;
        if ({l_gnt, mem_we} !== 2'b11 || mem_addr !== AW'(8)) begin
            errors++; $display("FAIL lock_wr got %b addr %0d expected 11 8", {l_gnt, mem_we}, mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk1);
            l_req = 1'b0; l_we = 1'b0;
            d_req = 1'b1; d_addr = AW'(8);
            i_req = 1'b1;
            #1;
            checks++;
            if ({locked, d_gnt, i_gnt, mem_en} !== 4'b1000) begin
                errors++; $display("FAIL lock_hold%0d got %b expected 1000", k, {locked, d_gnt, i_gnt, mem_en});
            end
        end
        @(negedge clk1);
        i_req = 1'b0;
        l_req = 1'b1; l_we = 1'b0; l_addr = AW'(8); l_lock = 1'b0;
        #1;
        checks++;
        if ({locked, l_gnt, d_gnt} !== 3'b110) begin
            errors++; $display("FAIL lock_exit got %b expected 110", {locked, l_gnt, d_gnt});
        end
        @(negedge clk1);
        l_req = 1'b0;
        #1;
        checks++;
        if ({locked, d_gnt, l_rvalid} !== 3'b011 || rdata !== 32'hfc000000) begin
            errors++; $display("FAIL lock_after got %b/%h expected 011/fc000000", {locked, d_gnt, l_rvalid}, rdata);
        end
        @(negedge clk1);
        idle_inputs();
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || rdata !== 32'hfc000000) begin
            errors++; $display("FAIL lock_dread got %b/%h expected 1/fc000000", d_rvalid, rdata);
        end
        ref_mem[8] = 32'hfc000000;
        @(negedge clk1);
    endtask

    task automatic test_aging();
        int nl;
        nl = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk1);
            d_req = 1'b1; d_we = 1'b0; d_addr = AW'(cyc);
            l_req = 1'b1; l_we = 1'b1; l_addr = AW'(20); l_wdata = 32'h0000abcd; l_lock = 1'b0;
            #1;
            if (l_gnt === 1'b1) nl++;
            checks++;
            if ({d_gnt, l_gnt} !== ((AGING && cyc == 5) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL aging_c%0d got %b expected %b", cyc, {d_gnt, l_gnt},
                                   ((AGING && cyc == 5) ? 2'b01 : 2'b10));
            end
        end
        checks++;
        if (nl != (AGING ? 1 : 0)) begin errors++; $display("FAIL aging_count got %0d expected %0d", nl, AGING ? 1 : 0); end
        @(negedge clk1);
        idle_inputs();
    endtask

    task automatic test_random();
        bit            pd, pi, pl, wd, wl, m_locked;
        logic [AW-1:0] ad, ai, al, e_addr;
        logic [DW-1:0] dd, dl, e_wdata, e_rdata;
        int            m_age, g, prev_rd;
        int            order [$];
        bit            e_we;
        preload();
        @(negedge clk1);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk1);
        rst_n = 1'b1;
        pd = 0; pi = 0; pl = 0; wd = 0; wl = 0;
        ad = '0; ai = '0; al = '0; dd = '0; dl = '0;
        m_locked = 0; m_age = 0; prev_rd = 0; e_rdata = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk1);
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1; ad = AW'($urandom_range(0, 15)); wd = ($urandom_range(0, 2) == 0); dd = $urandom;
            end
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1; ai = AW'($urandom_range(0, 15));
            end
            if (!pl && $urandom_range(0, 2) == 0) begin
                pl = 1; al = AW'($urandom_range(0, 15)); wl = ($urandom_range(0, 1) == 0); dl = $urandom;
            end
            d_req = pd; d_we = wd; d_addr = ad; d_wdata = dd;
            i_req = pi; i_addr = ai;
            l_req = pl; l_we = wl; l_addr = al; l_wdata = dl;
            l_lock = ($urandom_range(0, 9) < 3);
            #1;
            // Port codes: 1=D 2=I 3=L; pick the first requesting port in priority order
            order.delete();
            if (m_locked) order = '{3};
            else if (AGING && pl && m_age == AGE_MAX) order = '{3, 1, 2};
            else order = '{1, 2, 3};
            g = 0;
            foreach (order[k]) begin
                if (g == 0 && ((order[k] == 1 && pd) || (order[k] == 2 && pi) || (order[k] == 3 && pl))) g = order[k];
            end
            checks++;
            if ({d_gnt, i_gnt, l_gnt, mem_en, locked} !== {g == 1, g == 2, g == 3, g != 0, m_locked}) begin
                errors++; $display("FAIL rnd_gnt c%0d got %b expected %b", c, {d_gnt, i_gnt, l_gnt, mem_en, locked},
                                   {g == 1, g == 2, g == 3, g != 0, m_locked});
            end
            checks++;
            if ({d_rvalid, i_rvalid, l_rvalid} !== {prev_rd == 1, prev_rd == 2, prev_rd == 3} ||
                (prev_rd != 0 && rdata !== e_rdata)) begin
                errors++; $display("FAIL rnd_read c%0d got %b/%h expected %b/%h", c, {d_rvalid, i_rvalid, l_rvalid}, rdata,
                                   {prev_rd == 1, prev_rd == 2, prev_rd == 3}, e_rdata);
            end
            e_addr = (g == 1) ? ad : (g == 2) ? ai : al;
            e_we = (g == 1) ? wd : (g == 3) ? wl : 1'b0;
            e_wdata = (g == 1) ? dd : dl;
            if (g != 0) begin
                checks++;
                if (mem_addr !== e_addr || mem_we !== e_we || (e_we && mem_wdata !== e_wdata)) begin
                    errors++; $display("FAIL rnd_bus c%0d got %0d/%b/%h expected %0d/%b/%h", c, mem_addr, mem_we, mem_wdata,
                                       e_addr, e_we, e_wdata);
                end
            end
            prev_rd = (g != 0 && !e_we) ? g : 0;
            if (prev_rd != 0) e_rdata = ref_mem[e_addr];
            if (g != 0 && e_we) ref_mem[e_addr] = e_wdata;
            if (g == 3 || !pl) m_age = 0;
            else if (!m_locked) m_age++;
            if (!m_locked && g == 3 && l_lock) m_locked = 1;
            else if (m_locked && !l_lock) m_locked = 0;
            if (g == 1) pd = 0;
            if (g == 2) pi = 0;
            if (g == 3) pl = 0;
        end
        @(negedge clk1);
        idle_inputs();
    endtask

    initial begin
        mem_rdata = '0;
        idle_inputs();
        preload();
        test_reset();
        test_priority();
        test_fetch_stream();
        test_write();
        test_lock();
        test_aging();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
